// File: rtl/dumper_pkg.sv
// Shared types and frame-geometry constants for the pipeline state dumper.
package dumper_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HDR  = 3'd1,
    PC   = 3'd2,
    REGS = 3'd3,
    MEMS = 3'd4,
    CSUM = 3'd5
  } state_t;

  localparam logic [7:0] HEADER_BYTE_DEF = 8'hA5;
  localparam int NUM_REGS_DEF      = 32;
  localparam int NUM_MEM_WORDS_DEF = 10;

  function automatic int reg_bytes(int nr);
    return 4 * nr;
  endfunction

  function automatic int mem_bytes(int nm);
    return 4 * nm;
  endfunction

  // header + two PC bytes + checksum surround the register and memory images
  function automatic int frame_bytes(int nr, int nm);
    return 4 + reg_bytes(nr) + mem_bytes(nm);
  endfunction

  localparam int REG_BYTES   = reg_bytes(NUM_REGS_DEF);
  localparam int MEM_BYTES   = mem_bytes(NUM_MEM_WORDS_DEF);
  localparam int FRAME_BYTES = frame_bytes(NUM_REGS_DEF, NUM_MEM_WORDS_DEF);

endpackage

// File: rtl/dump_byte_select.sv
// Maps (state, frame byte index, shadow copy) to the payload byte for that slot.
module dump_byte_select
  import dumper_pkg::*;
#(
  parameter int NUM_REGS      = 32,
  parameter int NUM_MEM_WORDS = 10,
  parameter int PC_WIDTH      = 10,
  parameter int IDX_W         = 8
) (
  input  state_t                         state_i,
  input  logic [IDX_W-1:0]               idx_i,
  input  logic [PC_WIDTH-1:0]            pc_i,
  input  logic [32*NUM_REGS-1:0]         regs_i,
  input  logic [32*NUM_MEM_WORDS-1:0]    mems_i,
  output logic [7:0]                     byte_o
);

  localparam int RB = reg_bytes(NUM_REGS);

  logic [15:0]      pc_ext;
  logic [IDX_W-1:0] reg_off, mem_off;

  assign pc_ext  = 16'(pc_i);
  // Little-endian words laid end to end: byte k of the image sits at bit 8k.
  assign reg_off = idx_i - IDX_W'(3);
  assign mem_off = idx_i - IDX_W'(3 + RB);

  always_comb begin
    byte_o = 8'h00;
    case (state_i)
      PC:      byte_o = (idx_i == IDX_W'(1)) ? pc_ext[7:0] : pc_ext[15:8];
      REGS:    byte_o = 8'(regs_i >> {reg_off, 3'b000});
      MEMS:    byte_o = 8'(mems_i >> {mem_off, 3'b000});
      default: byte_o = 8'h00;
    endcase
  end

endmodule

// File: rtl/pipeline_state_dumper.sv
// Freezes PC/regfile/dmem on request and streams a checksummed byte frame to UART TX.
module pipeline_state_dumper
  import dumper_pkg::*;
#(
  parameter int         NUM_REGS      = NUM_REGS_DEF,
  parameter int         NUM_MEM_WORDS = NUM_MEM_WORDS_DEF,
  parameter int         PC_WIDTH      = 10,
  parameter logic [7:0] HEADER_BYTE   = HEADER_BYTE_DEF
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          dump_req,
  input  logic [PC_WIDTH-1:0]           pc_in,
  input  logic [32*NUM_REGS-1:0]        regs_in,
  input  logic [32*NUM_MEM_WORDS-1:0]   mems_in,
  output logic [7:0]                    tx_data,
  output logic                          tx_valid,
  input  logic                          tx_ready,
  output logic                          busy,
  output logic                          done
);

  localparam int RB    = reg_bytes(NUM_REGS);
  localparam int MB    = mem_bytes(NUM_MEM_WORDS);
  localparam int FB    = frame_bytes(NUM_REGS, NUM_MEM_WORDS);
  localparam int IDX_W = $clog2(FB);

  localparam logic [IDX_W-1:0] PC_LAST  = IDX_W'(2);
  localparam logic [IDX_W-1:0] REG_LAST = IDX_W'(2 + RB);
  localparam logic [IDX_W-1:0] MEM_LAST = IDX_W'(2 + RB + MB);

  state_t                        state_q, state_d;
  logic [IDX_W-1:0]              idx_q, idx_d;
  logic [7:0]                    csum_q, csum_d;
  logic [7:0]                    tx_data_q, tx_data_d;
  logic                          tx_valid_q, busy_q, done_q, done_d;
  logic                          capture;
  logic [7:0]                    sel_byte;

  logic [PC_WIDTH-1:0]           pc_q;
  logic [32*NUM_REGS-1:0]        regs_q;
  logic [32*NUM_MEM_WORDS-1:0]   mems_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    csum_d  = csum_q;
    done_d  = 1'b0;
    capture = 1'b0;
    if (state_q == IDLE) begin
      if (dump_req) begin
        state_d = HDR;
        idx_d   = '0;
        csum_d  = '0;
        capture = 1'b1;
      end
    end else if (tx_ready) begin
      idx_d = idx_q + IDX_W'(1);
      if (state_q == PC || state_q == REGS || state_q == MEMS)
        csum_d = csum_q ^ tx_data_q;
      case (state_q)
        HDR:  state_d = PC;
        PC:   if (idx_q == PC_LAST)  state_d = REGS;
        REGS: if (idx_q == REG_LAST) state_d = MEMS;
        MEMS: if (idx_q == MEM_LAST) state_d = CSUM;
        CSUM: begin
          state_d = IDLE;
          idx_d   = '0;
          done_d  = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Byte for the next cycle is looked up from the next state/index so tx_data stays registered.
  dump_byte_select #(
    .NUM_REGS      (NUM_REGS),
    .NUM_MEM_WORDS (NUM_MEM_WORDS),
    .PC_WIDTH      (PC_WIDTH),
    .IDX_W         (IDX_W)
  ) u_sel (
    .state_i (state_d),
    .idx_i   (idx_d),
    .pc_i    (pc_q),
    .regs_i  (regs_q),
    .mems_i  (mems_q),
    .byte_o  (sel_byte)
  );

  always_comb begin
    tx_data_d = 8'h00;
    case (state_d)
      IDLE:    tx_data_d = 8'h00;
      HDR:     tx_data_d = HEADER_BYTE;
      CSUM:    tx_data_d = csum_d;
      default: tx_data_d = sel_byte;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      csum_q     <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      csum_q     <= csum_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= (state_d != IDLE);
      busy_q     <= (state_d != IDLE);
      done_q     <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (capture) begin
      pc_q   <= pc_in;
      regs_q <= regs_in;
      mems_q <= mems_in;
    end
  end

  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_pipeline_state_dumper.sv
// Randomized bench for pipeline_state_dumper against a byte-queue frame model.
module tb_pipeline_state_dumper;
  localparam int NR = 32, NM = 10, PW = 10;
  localparam int FB = 4 + 4*NR + 4*NM;

  logic clk = 1'b0;
  logic reset, dump_req, tx_ready;
  logic [PW-1:0] pc_in;
  logic [32*NR-1:0] regs_in;
  logic [32*NM-1:0] mems_in;
  logic [7:0] tx_data;
  logic tx_valid, busy, done;

  pipeline_state_dumper dut (
    .clk(clk), .reset(reset), .dump_req(dump_req), .pc_in(pc_in),
    .regs_in(regs_in), .mems_in(mems_in), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  bit bp = 1'b0;

  logic [7:0] frame[$];
  logic [7:0] got[$];
  logic [7:0] basic[$];
  bit m_busy = 1'b0, m_done = 1'b0;
  int m_pos = 0, frames_done = 0;
  bit prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Frame as a flat byte list, straight from the layout rules.
  function automatic void build_frame();
    logic [7:0] cs;
    logic [15:0] pcw;
    frame.delete();
    frame.push_back(8'hA5);
    pcw = 16'(pc_in);
    frame.push_back(pcw[7:0]);
    frame.push_back(pcw[15:8]);
    for (int i = 0; i < NR; i++)
      for (int k = 0; k < 4; k++) frame.push_back(regs_in[32*i + 8*k +: 8]);
    for (int j = 0; j < NM; j++)
      for (int k = 0; k < 4; k++) frame.push_back(mems_in[32*j + 8*k +: 8]);
    cs = 8'h00;
    for (int b = 1; b < frame.size(); b++) cs ^= frame[b];
    frame.push_back(cs);
  endfunction

  always @(negedge clk) begin
    if (m_busy) begin
      chk("tx_valid", {31'b0, tx_valid}, 32'd1);
      chk("busy", {31'b0, busy}, 32'd1);
      chk("tx_data", {24'b0, tx_data}, {24'b0, frame[m_pos]});
      if (prev_stall) chk("stall_hold", {24'b0, tx_data}, {24'b0, prev_data});
    end else begin
      chk("tx_valid_idle", {31'b0, tx_valid}, 32'd0);
      chk("busy_idle", {31'b0, busy}, 32'd0);
      chk("tx_data_idle", {24'b0, tx_data}, 32'd0);
    end
    chk("done", {31'b0, done}, {31'b0, m_done});
    if (tx_valid && tx_ready) got.push_back(tx_data);
    prev_stall = m_busy && !tx_ready;
    prev_data  = tx_data;
    if (reset) begin
      m_busy = 1'b0; m_done = 1'b0; prev_stall = 1'b0;
    end else if (m_busy) begin
      m_done = 1'b0;
      if (tx_ready) begin
        m_pos++;
        if (m_pos == FB) begin
          m_busy = 1'b0; m_done = 1'b1; frames_done++;
        end
      end
    end else begin
      m_done = 1'b0;
      if (dump_req) begin
        build_frame(); m_busy = 1'b1; m_pos = 0;
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
    tx_ready = bp ? ($urandom_range(0, 99) < 30) : 1'b1;
  endtask

  task automatic pulse();
    dump_req = 1'b1; step(); dump_req = 1'b0;
  endtask

  task automatic wait_frames(input int target);
    for (int i = 0; i < 4000 && frames_done < target; i++) step();
    chk("frame_timeout", frames_done, target);
  endtask

  task automatic wait_pos(input int n);
    for (int i = 0; i < 4000 && m_pos < n; i++) step();
    if (m_pos < n) begin
      checks++; errors++;
      $display("FAIL pos_timeout: got %0d expected %0d", m_pos, n);
    end
  endtask

  task automatic run_frame();
    int f0;
    f0 = frames_done;
    pulse();
    wait_frames(f0 + 1);
    step(); step();
  endtask

  task automatic set_basic();
    pc_in = 10'h2C3;
    for (int i = 0; i < NR; i++) regs_in[32*i +: 32] = 32'(i);
    for (int j = 0; j < NM; j++) mems_in[32*j +: 32] = 32'h100 + 32'(j);
  endtask

  task automatic set_random();
    pc_in = PW'($urandom);
    for (int i = 0; i < NR; i++) regs_in[32*i +: 32] = $urandom;
    for (int j = 0; j < NM; j++) mems_in[32*j +: 32] = $urandom;
  endtask

  initial begin
    int f0, nz;
    reset = 1'b1; dump_req = 1'b0; tx_ready = 1'b1;
    pc_in = '0; regs_in = '0; mems_in = '0;
    step(); step();
    chk("reset_busy", {31'b0, busy}, 32'd0);
    chk("reset_valid", {31'b0, tx_valid}, 32'd0);
    chk("reset_data", {24'b0, tx_data}, 32'd0);
    reset = 1'b0;
    step();

    // all-zero state
    got.delete();
    run_frame();
    chk("zero_len", got.size(), FB);
    chk("zero_hdr", {24'b0, got[0]}, 32'hA5);
    nz = 0;
    for (int b = 1; b < got.size(); b++) if (got[b] != 8'h00) nz++;
    chk("zero_payload", nz, 0);

    // basic frame with hand-computed anchors
    set_basic();
    got.delete();
    run_frame();
    chk("basic_len", got.size(), FB);
    chk("basic_hdr", {24'b0, got[0]}, 32'hA5);
    chk("basic_pc0", {24'b0, got[1]}, 32'hC3);
    chk("basic_pc1", {24'b0, got[2]}, 32'h02);
    chk("basic_reg1_b0", {24'b0, got[7]}, 32'h01);
    chk("basic_reg31_b0", {24'b0, got[3+124]}, 32'h1F);
    chk("basic_mem0_b0", {24'b0, got[131]}, 32'h00);
    chk("basic_mem0_b1", {24'b0, got[132]}, 32'h01);
    chk("basic_mem9_b0", {24'b0, got[131+36]}, 32'h09);
    chk("basic_csum", {24'b0, got[FB-1]}, 32'hC0);
    basic = got;

    // back-pressure
    bp = 1'b1;
    got.delete();
    run_frame();
    bp = 1'b0; step();
    chk("bp_len", got.size(), FB);
    nz = 0;
    for (int b = 0; b < FB && b < got.size(); b++) if (got[b] != basic[b]) nz++;
    chk("bp_bytes", nz, 0);

    // snapshot isolation
    got.delete();
    f0 = frames_done;
    pulse();
    step();
    regs_in = '1; mems_in = '1; pc_in = '1;
    wait_frames(f0 + 1);
    step();
    nz = 0;
    for (int b = 0; b < FB && b < got.size(); b++) if (got[b] != basic[b]) nz++;
    chk("iso_bytes", nz, 0);
    chk("iso_len", got.size(), FB);
    set_basic();

    // requests while busy are dropped
    got.delete();
    f0 = frames_done;
    pulse();
    wait_pos(5); pulse();
    wait_pos(100); pulse();
    wait_frames(f0 + 1);
    for (int i = 0; i < 5; i++) step();
    chk("busy_req_frames", frames_done, f0 + 1);
    chk("busy_req_len", got.size(), FB);

    // request held through done starts a second frame
    got.delete();
    f0 = frames_done;
    dump_req = 1'b1;
    wait_frames(f0 + 1);
    step();
    dump_req = 1'b0;
    wait_frames(f0 + 2);
    step(); step();
    chk("held_len", got.size(), 2*FB);
    if (got.size() == 2*FB) begin
      chk("held_csum1", {24'b0, got[FB-1]}, 32'hC0);
      chk("held_hdr2", {24'b0, got[FB]}, 32'hA5);
    end

    // reset mid-frame
    got.delete();
    f0 = frames_done;
    pulse();
    wait_pos(50);
    reset = 1'b1; step(); reset = 1'b0;
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_valid", {31'b0, tx_valid}, 32'd0);
    for (int i = 0; i < 4; i++) step();
    chk("rst_no_done", frames_done, f0);
    set_random();
    got.delete();
    run_frame();
    chk("rst_new_len", got.size(), FB);
    chk("rst_new_hdr", {24'b0, got[0]}, 32'hA5);

    // randomized frames, some with back-pressure
    for (int r = 0; r < 4; r++) begin
      set_random();
      bp = r[0];
      got.delete();
      run_frame();
      bp = 1'b0; step();
      chk("rand_len", got.size(), FB);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
